// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT butterfly datapath.
// Q is the 28-bit NTT-friendly prime 2^28 - 2^16 + 1.
package ntt_pkg;

    localparam int DEF_DATA_W   = 28;
    localparam int DEF_MULT_LAT = 6;

    localparam logic [DEF_DATA_W-1:0] Q = 28'd268369921;

    typedef enum logic {
        BF_CT = 1'b0,  // Cooley-Tukey, forward transform
        BF_GS = 1'b1   // Gentleman-Sande, inverse transform
    } bf_mode_e;

endpackage

// File: rtl/bfly_addsub.sv
// Combinational modular add/sub pair: sum = (a + b) mod q, diff = (a - b) mod q.
// Operands must already be reduced below q.
module bfly_addsub #(
    parameter int DATA_W = 28
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] sum,
    output logic [DATA_W-1:0] diff
);

    logic [DATA_W:0] sum_full;

    assign sum_full = {1'b0, a} + {1'b0, b};
    assign sum      = (sum_full >= {1'b0, q}) ? DATA_W'(sum_full - {1'b0, q})
                                              : sum_full[DATA_W-1:0];

    // A negative difference wraps mod 2^DATA_W, so adding q lands back in [0, q).
    assign diff     = (a >= b) ? (a - b) : (a - b + q);

endmodule

// File: rtl/ntt_modmul.sv
// Pipelined modular multiplier: p = (a * b) mod q, LAT register stages deep.
// The full product is carried through LAT-1 stages and reduced in the last one.
module ntt_modmul
    import ntt_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LAT    = DEF_MULT_LAT   // must be >= 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] p
);

    localparam int PW = 2 * DATA_W;

    logic [PW-1:0] prod_pipe [LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the pipeline array is a plain register file, so clearing it in
            // a loop is cheap and keeps stale products from ever reaching p.
            for (int i = 0; i < LAT - 1; i++) prod_pipe[i] <= '0;
            p <= '0;
        end else begin
            prod_pipe[0] <= PW'(a) * PW'(b);
            for (int i = 1; i < LAT - 1; i++) prod_pipe[i] <= prod_pipe[i-1];
            p <= DATA_W'(prod_pipe[LAT-2] % PW'(q));
        end
    end

endmodule

// File: rtl/ntt_butterfly.sv
// Fixed-latency CT/GS butterfly for NTT/INTT, latency MULT_LAT + 2, one issue per cycle.
// Stage 0 forms the operands, one shared multiplier, final stage combines.
module ntt_butterfly
    import ntt_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MULT_LAT = DEF_MULT_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              mode,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [DATA_W-1:0] w,
    input  logic [DATA_W-1:0] q,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_x,
    output logic [DATA_W-1:0] out_y
);

    localparam int L = MULT_LAT + 2;

    // Stage 0 holds the pass-through operand (a), the multiplicand (b) and w.
    logic [DATA_W-1:0] s0_a, s0_b, s0_w;
    logic [DATA_W-1:0] s0_sum, s0_diff;
    logic [DATA_W-1:0] a_dly [MULT_LAT];
    logic [DATA_W-1:0] mul_p;
    logic [DATA_W-1:0] fin_sum, fin_diff;

    // valid_sr/mode_sr cover stages 0..L-2; out_valid is the final valid stage.
    logic [L-2:0]      valid_sr;
    bf_mode_e          mode_sr [L-1];
    bf_mode_e          in_mode;
    bf_mode_e          fin_mode;

    assign in_mode  = bf_mode_e'(mode);
    assign fin_mode = mode_sr[L-2];

    bfly_addsub #(.DATA_W(DATA_W)) u_s0_addsub (
        .a    (x),
        .b    (y),
        .q    (q),
        .sum  (s0_sum),
        .diff (s0_diff)
    );

    ntt_modmul #(.DATA_W(DATA_W), .LAT(MULT_LAT)) u_modmul (
        .clk (clk),
        .rst (rst),
        .a   (s0_b),
        .b   (s0_w),
        .q   (q),
        .p   (mul_p)
    );

    bfly_addsub #(.DATA_W(DATA_W)) u_fin_addsub (
        .a    (a_dly[MULT_LAT-1]),
        .b    (mul_p),
        .q    (q),
        .sum  (fin_sum),
        .diff (fin_diff)
    );

    // NOTE: every register here is state, so only non-blocking assignments are used;
    // a blocking write would let later stages see this cycle's value and collapse the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_a      <= '0;
            s0_b      <= '0;
            s0_w      <= '0;
            valid_sr  <= '0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            for (int i = 0; i < MULT_LAT; i++) a_dly[i]   <= '0;
            for (int i = 0; i < L - 1; i++)    mode_sr[i] <= BF_CT;
        end else begin
            // Both modes multiply s0_b by w, so the multiplier needs no operand mux.
            s0_a <= (in_mode == BF_GS) ? s0_sum  : x;
            s0_b <= (in_mode == BF_GS) ? s0_diff : y;
            s0_w <= w;

            a_dly[0] <= s0_a;
            for (int i = 1; i < MULT_LAT; i++) a_dly[i] <= a_dly[i-1];

            valid_sr   <= {valid_sr[L-3:0], in_valid};
            mode_sr[0] <= in_mode;
            for (int i = 1; i < L - 1; i++) mode_sr[i] <= mode_sr[i-1];

            out_valid <= valid_sr[L-2];
            // NOTE: the enable lives inside a clocked block, so holding the result
            // between beats is a plain register hold, not an inferred latch.
            if (valid_sr[L-2]) begin
                out_x <= (fin_mode == BF_CT) ? fin_sum  : a_dly[MULT_LAT-1];
                out_y <= (fin_mode == BF_CT) ? fin_diff : mul_p;
            end
        end
    end

endmodule
